// File: rtl/sign_extender.sv
`default_nettype none
// ============================================================================
// Module      : sign_extender
// Description : Immediate extender for a MIPS-style datapath. Widens the
//               instruction immediate to the operand width using one of four
//               modes (sign-extend, zero-extend, LUI upper, branch offset <<2).
//               The result is registered with one cycle of latency and a
//               valid flag travels alongside the data.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_extender #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [1:0]           mode,
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] data_out
);

  // Number of bits added above the immediate.
  localparam int c_EXT_W = OUT_WIDTH - IN_WIDTH;

  localparam logic [1:0] c_MODE_SEXT = 2'b00;
  localparam logic [1:0] c_MODE_ZEXT = 2'b01;
  localparam logic [1:0] c_MODE_LUI  = 2'b10;
  localparam logic [1:0] c_MODE_BR   = 2'b11;

  logic [OUT_WIDTH-1:0] w_sext;
  logic [OUT_WIDTH-1:0] w_zext;
  logic [OUT_WIDTH-1:0] w_ext;
  logic [OUT_WIDTH-1:0] data_d;
  logic [OUT_WIDTH-1:0] data_q;
  logic                 valid_q;

  assign w_sext = {{c_EXT_W{data_in[IN_WIDTH-1]}}, data_in};
  assign w_zext = {{c_EXT_W{1'b0}}, data_in};

  // Select the extension; shifts drop bits off the top of the output width,
  // which also truncates the immediate in LUI mode when the output is narrow.
  always_comb begin
    w_ext = w_sext;
    case (mode)
      c_MODE_SEXT: w_ext = w_sext;
      c_MODE_ZEXT: w_ext = w_zext;
      c_MODE_LUI:  w_ext = w_zext << c_EXT_W;
      c_MODE_BR:   w_ext = w_sext << 2;
      default:     w_ext = w_sext;
    endcase
  end

  // Capture a new result only for valid inputs so idle-cycle data is ignored.
  always_comb begin
    data_d = data_q;
    if (in_valid) begin
      data_d = w_ext;
    end
  end

  // Output registers; reset clears them immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= in_valid;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sign_extender.sv
`default_nettype none
// ============================================================================
// Module      : tb_sign_extender
// Description : Self-checking bench for sign_extender. Expected results are
//               queued when stimulus is driven and compared when the DUT
//               presents a valid output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sign_extender;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  mode;
  logic [15:0] data_in;
  logic        out_valid;
  logic [31:0] data_out;

  int          n_cmp;
  int          n_err;
  logic [31:0] q_exp[$];
  logic [31:0] last_data;

  sign_extender #(
    .IN_WIDTH  (16),
    .OUT_WIDTH (32)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for the 16->32 configuration.
  function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] d);
    logic [31:0] s;
    s = {{16{d[15]}}, d};
    case (m)
      2'b00:   model = s;
      2'b01:   model = {16'h0000, d};
      2'b10:   model = {d, 16'h0000};
      default: model = {s[29:0], 2'b00};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then check the registered outputs #1 after the edge.
  task automatic step(input string tag, input logic v, input logic [1:0] m, input logic [15:0] d);
    logic [31:0] e;
    in_valid = v;
    mode     = m;
    data_in  = d;
    if (v) q_exp.push_back(model(m, d));
    @(posedge clk);
    #1;
    chk({tag, ".vld"}, {31'd0, out_valid}, {31'd0, v});
    if (v) begin
      if (q_exp.size() == 0) begin
        chk({tag, ".empty"}, 32'd1, 32'd0);
      end else begin
        e = q_exp.pop_front();
        chk({tag, ".dat"}, data_out, e);
        last_data = e;
      end
    end else begin
      chk({tag, ".hold"}, data_out, last_data);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    last_data = 32'd0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    mode      = 2'b00;
    data_in   = 16'h0000;

    // Asynchronous reset assertion between edges.
    #2 rst_n = 1'b0;
    #1;
    chk("rst.dat", data_out, 32'd0);
    chk("rst.vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle0", 1'b0, 2'b00, 16'h0000);
    step("idle1", 1'b0, 2'b00, 16'h0000);

    // Sign extension, back to back.
    step("sx32",   1'b1, 2'b00, 16'd32);
    chk("sx32.lit", data_out, 32'h0000_0020);
    step("sx128",  1'b1, 2'b00, 16'd128);
    step("sxm120", 1'b1, 2'b00, 16'hFF88);
    chk("sxm120.lit", data_out, 32'hFFFF_FF88);
    step("sx0",    1'b1, 2'b00, 16'h0000);

    // MSB boundaries.
    step("b7fff", 1'b1, 2'b00, 16'h7FFF);
    chk("b7fff.lit", data_out, 32'h0000_7FFF);
    step("b8000", 1'b1, 2'b00, 16'h8000);
    chk("b8000.lit", data_out, 32'hFFFF_8000);
    step("bffff", 1'b1, 2'b00, 16'hFFFF);

    // Other modes.
    step("zx",   1'b1, 2'b01, 16'hFF88);
    chk("zx.lit", data_out, 32'h0000_FF88);
    step("lui",  1'b1, 2'b10, 16'h1234);
    chk("lui.lit", data_out, 32'h1234_0000);
    step("brm1", 1'b1, 2'b11, 16'hFFFF);
    chk("brm1.lit", data_out, 32'hFFFF_FFFC);
    step("br4",  1'b1, 2'b11, 16'h0004);
    chk("br4.lit", data_out, 32'h0000_0010);

    // Hold while idle, including X on data_in.
    step("hold0", 1'b0, 2'b01, 16'hAAAA);
    step("hold1", 1'b0, 2'b10, 16'h5555);
    step("holdx", 1'b0, 2'b00, 16'hxxxx);

    // A few random transactions in all modes.
    for (int i = 0; i < 12; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           16'($urandom_range(0, 65535)));
    end

    // Reset mid-stream: a valid result is on the outputs, clear between edges.
    step("pre",  1'b1, 2'b00, 16'h8001);
    in_valid = 1'b1;
    mode     = 2'b10;
    data_in  = 16'h00FF;
    #3 rst_n = 1'b0;
    #1;
    chk("mrst.dat", data_out, 32'd0);
    chk("mrst.vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("mrst.held", data_out, 32'd0);
    q_exp.delete();
    last_data = 32'd0;
    in_valid  = 1'b0;
    rst_n     = 1'b1;
    step("post0", 1'b0, 2'b00, 16'h1111);
    step("post1", 1'b1, 2'b11, 16'h8000);
    chk("post1.lit", data_out, 32'hFFFE_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
